// File: rtl/cyclic_code_pkg.sv
// Shared definitions for the (7,4) cyclic code generated by g(x) = x^3 + x + 1,
// used by both the systematic encoder and the serial decoder.
package cyclic_code_pkg;

    localparam int N = 7;
    localparam int K = 4;
    localparam int R = 3;

    // Low-order coefficients of g(x); the x^3 term is implied by the register feedback.
    localparam logic [R-1:0] G_LOW = 3'b011;

    localparam logic [2:0] CNT_LAST = 3'd6;

    typedef enum logic [1:0] {
        RECV,
        FIX,
        OUT
    } state_t;

    // Each nonzero syndrome equals x^i mod g(x) for exactly one bit position i.
    function automatic logic [N-1:0] syndrome_to_mask(input logic [R-1:0] syn);
        logic [N-1:0] mask;
        mask = '0;
        case (syn)
            3'b001:  mask = 7'b000_0001;
            3'b010:  mask = 7'b000_0010;
            3'b100:  mask = 7'b000_0100;
            3'b011:  mask = 7'b000_1000;
            3'b110:  mask = 7'b001_0000;
            3'b111:  mask = 7'b010_0000;
            3'b101:  mask = 7'b100_0000;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/cyclic_decoder_if.sv
// Serial bit input and parallel decoded-word output of the cyclic decoder,
// both as valid/ready handshakes.
interface cyclic_decoder_if;
    import cyclic_code_pkg::*;

    logic         in_valid;
    logic         in_bit;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_data;
    logic [R-1:0] out_syndrome;
    logic         out_error;
    logic         out_corrected;

    // Environment side: produces codeword bits, consumes decoded words.
    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome, out_error, out_corrected
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_data, out_syndrome, out_error, out_corrected
    );

endinterface

// File: rtl/cyclic_syndrome_lfsr.sv
// Serial polynomial division by g(x): after the last shift, syn holds the input
// sequence (highest degree first) modulo g(x).
module cyclic_syndrome_lfsr
    import cyclic_code_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift,
    input  logic         din,
    output logic [R-1:0] syn
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn <= '0;
        end else if (clear) begin
            syn <= '0;
        end else if (shift) begin
            syn <= {syn[R-2:0], din} ^ (syn[R-1] ? G_LOW : '0);
        end
    end

endmodule

// File: rtl/cyclic_decoder.sv
// Receive-side (7,4) cyclic decoder: shifts in one codeword bit per handshake,
// corrects a single-bit error from the syndrome and presents the message.
module cyclic_decoder
    import cyclic_code_pkg::*;
#(
    parameter bit CORRECT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    cyclic_decoder_if.slave bus
);

    state_t       state;
    state_t       state_next;
    logic [2:0]   count;
    logic [N-1:0] buffer;
    logic [R-1:0] syndrome;
    logic [N-1:0] fixed;

    logic         ready;
    logic         valid;
    logic         accept;
    logic         last_bit;
    logic         release_word;

    logic [K-1:0] data_q;
    logic [R-1:0] syndrome_q;
    logic         error_q;
    logic         corrected_q;

    // in_ready is gated by rst so no bit is consumed while reset is held.
    assign ready        = (state == RECV) && !rst;
    assign valid        = (state == OUT);
    assign accept       = ready && bus.in_valid;
    assign last_bit     = accept && (count == CNT_LAST);
    assign release_word = valid && bus.out_ready;

    assign bus.in_ready      = ready;
    assign bus.out_valid     = valid;
    assign bus.out_data      = data_q;
    assign bus.out_syndrome  = syndrome_q;
    assign bus.out_error     = error_q;
    assign bus.out_corrected = corrected_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RECV;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: assign the default before the case so every path drives
        // state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            RECV:    if (last_bit) state_next = FIX;
            FIX:     state_next = OUT;
            OUT:     if (release_word) state_next = RECV;
            default: state_next = RECV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            buffer <= '0;
        end else if (accept) begin
            buffer <= {buffer[N-2:0], bus.in_bit};
            count  <= last_bit ? 3'd0 : count + 3'd1;
        end
    end

    // Cleared on release so the next word starts from an empty remainder.
    cyclic_syndrome_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .clear (release_word),
        .shift (accept),
        .din   (bus.in_bit),
        .syn   (syndrome)
    );

    assign fixed = buffer ^ (CORRECT_EN ? syndrome_to_mask(syndrome) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= '0;
            syndrome_q  <= '0;
            error_q     <= 1'b0;
            corrected_q <= 1'b0;
        end else if (state == FIX) begin
            data_q      <= fixed[N-1:N-K];
            syndrome_q  <= syndrome;
            error_q     <= |syndrome;
            corrected_q <= CORRECT_EN && (|syndrome);
        end
    end

endmodule

// File: tb/tb_cyclic_decoder.sv
// Self-checking bench for cyclic_decoder: a polynomial-arithmetic reference model
// predicts every word, and a per-cycle compare process checks both build variants.
module tb_cyclic_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b1;
    bit   rand_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cyclic_decoder_if bus1 ();
    cyclic_decoder_if bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_bit    = in_bit;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_bit    = in_bit;
    assign bus0.out_ready = out_ready;

    cyclic_decoder #(.CORRECT_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    cyclic_decoder #(.CORRECT_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // x^i mod g(x) by plain polynomial arithmetic
    function automatic logic [2:0] pow_of(input int i);
        logic [3:0] p;
        p = 4'd1;
        for (int k = 0; k < i; k++) begin
            p = p << 1;
            if (p[3]) p = p ^ 4'b1011;
        end
        return p[2:0];
    endfunction

    function automatic logic [2:0] syn_of(input logic [6:0] r);
        logic [2:0] s;
        s = 3'b000;
        for (int i = 0; i < 7; i++) if (r[i]) s = s ^ pow_of(i);
        return s;
    endfunction

    function automatic logic [6:0] fix_of(input logic [6:0] r);
        logic [2:0] s;
        s = syn_of(r);
        if (s == 3'b000) return r;
        for (int i = 0; i < 7; i++) if (pow_of(i) == s) return r ^ (7'd1 << i);
        return r;
    endfunction

    // Reference model: pending word with age in edges since the 7th accepted bit.
    bit         m_pending = 1'b0;
    int         m_age = 0;
    int         m_cnt = 0;
    int         m_words = 0;
    logic [6:0] m_rx = '0;
    logic [6:0] full;
    logic [6:0] fixed_w;
    logic [3:0] e1_data = '0;
    logic [3:0] e0_data = '0;
    logic [2:0] e_syn = '0;
    logic       e_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending <= 1'b0;
            m_age     <= 0;
            m_cnt     <= 0;
            m_rx      <= '0;
        end else if (m_pending) begin
            if (m_age >= 1 && out_ready) begin
                m_pending <= 1'b0;
                m_age     <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (in_valid) begin
            if (m_cnt == 6) begin
                full      = {m_rx[5:0], in_bit};
                fixed_w   = fix_of(full);
                e1_data   <= fixed_w[6:3];
                e0_data   <= full[6:3];
                e_syn     <= syn_of(full);
                e_err     <= (syn_of(full) != 3'b000);
                m_pending <= 1'b1;
                m_age     <= 0;
                m_cnt     <= 0;
                m_words   <= m_words + 1;
            end else begin
                m_rx  <= {m_rx[5:0], in_bit};
                m_cnt <= m_cnt + 1;
            end
        end
    end

    int  cyc = 0;
    int  last_rise = 0;
    int  prev_rise = 0;
    int  dut_words = 0;
    bit  prev_ov = 1'b0;

    always @(negedge clk) begin
        logic exp_rdy;
        logic exp_ov;
        exp_rdy = !rst && !m_pending;
        exp_ov  = !rst && m_pending && (m_age >= 1);
        cyc++;
        check("in_ready_c1", bus1.in_ready, exp_rdy);
        check("in_ready_c0", bus0.in_ready, exp_rdy);
        check("out_valid_c1", bus1.out_valid, exp_ov);
        check("out_valid_c0", bus0.out_valid, exp_ov);
        if (exp_ov) begin
            check("data_c1", bus1.out_data, e1_data);
            check("syn_c1", bus1.out_syndrome, e_syn);
            check("err_c1", bus1.out_error, e_err);
            check("cor_c1", bus1.out_corrected, e_err);
            check("data_c0", bus0.out_data, e0_data);
            check("syn_c0", bus0.out_syndrome, e_syn);
            check("err_c0", bus0.out_error, e_err);
            check("cor_c0", bus0.out_corrected, 1'b0);
        end
        if (rst) begin
            check("rst_data", bus1.out_data, 4'b0000);
            check("rst_syn", bus1.out_syndrome, 3'b000);
            check("rst_err", bus1.out_error, 1'b0);
            check("rst_cor", bus1.out_corrected, 1'b0);
        end
        if (bus1.out_valid && !prev_ov) begin
            prev_rise = last_rise;
            last_rise = cyc;
        end
        if (bus1.out_valid && out_ready) dut_words++;
        prev_ov = bus1.out_valid;
    end

    task automatic send_bit(input logic b, input bit sparse);
        bit acc;
        if (sparse) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                @(posedge clk);
                #1;
                if (rand_ready) out_ready = 1'($urandom);
            end
        end
        in_valid = 1'b1;
        in_bit   = b;
        acc      = 1'b0;
        for (int t = 0; t < 60 && !acc; t++) begin
            @(negedge clk);
            acc = !rst && !m_pending;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL bit_accept_timeout actual=0 required=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [6:0] w, input int nbits, input bit sparse);
        for (int i = 6; i > 6 - nbits; i--) send_bit(w[i], sparse);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.out_valid && n < 20);
        if (!bus1.out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic expect_word(input string tag, input logic [3:0] d1, input logic [2:0] s,
                               input logic e, input logic c1, input logic [3:0] d0,
                               input int exp_n);
        int n;
        wait_valid(n);
        if (exp_n > 0) check({tag, "_latency"}, 8'(n), 8'(exp_n));
        check({tag, "_data"}, bus1.out_data, d1);
        check({tag, "_syn"}, bus1.out_syndrome, s);
        check({tag, "_err"}, bus1.out_error, e);
        check({tag, "_cor"}, bus1.out_corrected, c1);
        check({tag, "_data_nocorr"}, bus0.out_data, d0);
        check({tag, "_cor_nocorr"}, bus0.out_corrected, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] pos_syn [7];
        logic [6:0] base;
        logic [6:0] w;
        logic [3:0] msg;
        int         p1;
        int         p2;
        int         n;

        pos_syn[0] = 3'b001; pos_syn[1] = 3'b010; pos_syn[2] = 3'b100; pos_syn[3] = 3'b011;
        pos_syn[4] = 3'b110; pos_syn[5] = 3'b111; pos_syn[6] = 3'b101;

        check("pin_syn_clean", syn_of(7'b1001110), 3'b000);
        check("pin_syn_c4", syn_of(7'b1011110), 3'b110);
        check("pin_fix_c4", fix_of(7'b1011110), 7'b1001110);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus1.in_ready, 1'b0);
        check("rst_out_valid", bus1.out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus1.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Clean word, then single error on c4
        feed_word(7'b1001110, 7, 1'b0);
        expect_word("clean", 4'b1001, 3'b000, 1'b0, 1'b0, 4'b1001, 2);
        feed_word(7'b1011110, 7, 1'b0);
        expect_word("err_c4", 4'b1001, 3'b110, 1'b1, 1'b1, 4'b1011, 2);

        // Every single-bit error position on 1010011
        base = 7'b1010011;
        for (int i = 0; i < 7; i++) begin
            w = base ^ (7'd1 << i);
            feed_word(w, 7, 1'b0);
            expect_word($sformatf("pos%0d", i), 4'b1010, pos_syn[i], 1'b1, 1'b1, w[6:3], 2);
        end
        feed_word(7'b0010011, 7, 1'b0);
        expect_word("nocorr_c6", 4'b1010, 3'b101, 1'b1, 1'b1, 4'b0010, 2);

        // Backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        feed_word(7'b1001110, 7, 1'b0);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            in_bit   = 1'($urandom);
            @(negedge clk);
            check("bp_in_ready", bus1.in_ready, 1'b0);
            check("bp_out_valid", bus1.out_valid, 1'b1);
            check("bp_data", bus1.out_data, 4'b1001);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_released", bus1.out_valid, 1'b0);
        @(posedge clk);
        #1;
        feed_word(7'b1010011, 7, 1'b0);
        expect_word("after_bp", 4'b1010, 3'b000, 1'b0, 1'b0, 4'b1010, 2);

        // Sparse input gives the same result as back-to-back
        feed_word(7'b1011110, 7, 1'b1);
        expect_word("sparse", 4'b1001, 3'b110, 1'b1, 1'b1, 4'b1011, 2);

        // Back-to-back throughput
        feed_word(7'b1001110, 7, 1'b0);
        feed_word(7'b1010011, 7, 1'b0);
        feed_word(7'b0110001, 7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("throughput", 8'(last_rise - prev_rise), 8'd9);

        // Reset after 4 bits discards the partial word
        feed_word(7'b1010011, 4, 1'b0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", bus1.in_ready, 1'b0);
        check("mid_rst_out_valid", bus1.out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        feed_word(7'b1010011, 7, 1'b0);
        expect_word("after_rst", 4'b1010, 3'b000, 1'b0, 1'b0, 4'b1010, 2);

        // Randomized words: clean, single and double errors, sparse input, random out_ready
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            msg = 4'($urandom_range(0, 15));
            w   = {msg, syn_of({msg, 3'b000})};
            case ($urandom_range(0, 2))
                1: w = w ^ (7'd1 << $urandom_range(0, 6));
                2: begin
                    p1 = $urandom_range(0, 6);
                    p2 = (p1 + $urandom_range(1, 6)) % 7;
                    w  = w ^ (7'd1 << p1) ^ (7'd1 << p2);
                end
                default: ;
            endcase
            feed_word(w, 7, 1'($urandom));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        check("word_count", 8'(dut_words), 8'(m_words));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
